// File: rtl/ip_filter_req_ctrl_if.sv
// Handshake bundle between the header parser, the IP blacklist filter and the
// lookup state machine; slave is the request controller, master is its environment.
interface ip_filter_req_ctrl_if;
    logic        hdr_valid;
    logic [31:0] hdr_src_ip;
    logic [31:0] hdr_dst_ip;
    logic        hdr_ready;
    logic        ip_filter_req;
    logic [31:0] search_ip;
    logic        ip_filter_done;
    logic        found;
    logic        res_valid;
    logic        res_drop;
    logic        res_rd;

    modport slave (
        input  hdr_valid, hdr_src_ip, hdr_dst_ip, ip_filter_done, found, res_rd,
        output hdr_ready, ip_filter_req, search_ip, res_valid, res_drop
    );

    modport master (
        output hdr_valid, hdr_src_ip, hdr_dst_ip, ip_filter_done, found, res_rd,
        input  hdr_ready, ip_filter_req, search_ip, res_valid, res_drop
    );
endinterface

// File: rtl/ip_filter_req_ctrl.sv
// Sequences src/dst blacklist lookups per buffered IP pair and returns a drop decision.
// Define IP_FILTER_STATS_EN to build the drop_count / timeout_count statistics ports.
module ip_filter_req_ctrl #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ip_filter_req_ctrl_if.slave   bus
`ifdef IP_FILTER_STATS_EN
    ,
    output logic [31:0]           drop_count,
    output logic [15:0]           timeout_count
`endif
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [5:0] {
        IDLE     = 6'b000001,
        REQ_SRC  = 6'b000010,
        WAIT_SRC = 6'b000100,
        REQ_DST  = 6'b001000,
        WAIT_DST = 6'b010000,
        RESULT   = 6'b100000
    } state_t;

    state_t        state;
    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [63:0]   head;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          pop;
    logic [31:0]   dst_q;
    logic [TW-1:0] timer;
    logic          req_q;
    logic [31:0]   search_q;
    logic          res_valid_q;
    logic          res_drop_q;
    logic          timeout_evt;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = bus.hdr_valid && !full;
    assign head  = mem[rd_ptr[AW-1:0]];
    // RESULT only ever holds with res_valid high, so res_rd alone qualifies the back-to-back pop
    assign pop   = !empty && ((state == IDLE) || ((state == RESULT) && bus.res_rd));

    assign timeout_evt = ((state == WAIT_SRC) || (state == WAIT_DST)) &&
                         !bus.ip_filter_done && (timer == TMAX);

    assign bus.hdr_ready     = !full;
    assign bus.ip_filter_req = req_q;
    assign bus.search_ip     = search_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_drop      = res_drop_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {bus.hdr_src_ip, bus.hdr_dst_ip};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            search_q    <= '0;
            res_valid_q <= 1'b0;
            res_drop_q  <= 1'b0;
            dst_q       <= '0;
            timer       <= '0;
        end else begin
            req_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        search_q <= head[63:32];
                        dst_q    <= head[31:0];
                        req_q    <= 1'b1;
                        state    <= REQ_SRC;
                    end
                end
                REQ_SRC: begin
                    timer <= '0;
                    state <= WAIT_SRC;
                end
                WAIT_SRC: begin
                    if (bus.ip_filter_done) begin
                        if (bus.found) begin
                            res_drop_q  <= 1'b1;
                            res_valid_q <= 1'b1;
                            state       <= RESULT;
                        end else begin
                            search_q <= dst_q;
                            req_q    <= 1'b1;
                            state    <= REQ_DST;
                        end
                    end else if (timeout_evt) begin
                        res_drop_q  <= 1'b1;
                        res_valid_q <= 1'b1;
                        state       <= RESULT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                REQ_DST: begin
                    timer <= '0;
                    state <= WAIT_DST;
                end
                WAIT_DST: begin
                    if (bus.ip_filter_done) begin
                        res_drop_q  <= bus.found;
                        res_valid_q <= 1'b1;
                        state       <= RESULT;
                    end else if (timeout_evt) begin
                        res_drop_q  <= 1'b1;
                        res_valid_q <= 1'b1;
                        state       <= RESULT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.res_rd) begin
                        res_valid_q <= 1'b0;
                        if (pop) begin
                            search_q <= head[63:32];
                            dst_q    <= head[31:0];
                            req_q    <= 1'b1;
                            state    <= REQ_SRC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IP_FILTER_STATS_EN
    logic drop_evt;
    assign drop_evt = (state == RESULT) && bus.res_rd && res_drop_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count    <= '0;
            timeout_count <= '0;
        end else begin
            if (drop_evt && (drop_count != '1))       drop_count    <= drop_count + 1'b1;
            if (timeout_evt && (timeout_count != '1)) timeout_count <= timeout_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_ip_filter_req_ctrl.sv
// Scoreboard bench for ip_filter_req_ctrl: a behavioural filter answers lookups, expected
// search IPs and drop decisions are queued at header accept and checked as the DUT produces them.
module tb_ip_filter_req_ctrl;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 64;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    ip_filter_req_ctrl_if bus();
`ifdef IP_FILTER_STATS_EN
    logic [31:0] drop_count;
    logic [15:0] timeout_count;
`endif

    ip_filter_req_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef IP_FILTER_STATS_EN
        ,
        .drop_count    (drop_count),
        .timeout_count (timeout_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit in_tbl(input logic [31:0] ip);
        return ip == 32'h0A00_0001;
    endfunction

    logic [31:0] exp_search[$];
    bit          exp_drop[$];
    bit          never_done   = 1'b0;
    int unsigned fixed_lat    = 2;
    int unsigned late_req     = 0;
    int unsigned late_ack     = 0;
    bit          hold_res     = 1'b0;
    int unsigned n_req        = 0;
    int unsigned req_cyc      = 0;
    int unsigned n_res        = 0;
    int unsigned rise_cyc     = 0;
    int unsigned acc_cyc      = 0;
    int unsigned exp_drops    = 0;
    int unsigned exp_timeouts = 0;

    // Behavioural filter: answers each request after fixed_lat cycles (random 2..34 when 0)
    int unsigned cnt      = 0;
    logic [31:0] held_ip  = '0;
    bit          prev_req = 1'b0;
    always @(negedge clk) begin
        bus.ip_filter_done = 1'b0;
        bus.found          = 1'b0;
        if (!reset_n) begin
            cnt      = 0;
            prev_req = 1'b0;
        end else begin
            if (cnt > 0) begin
                check("search_hold", bus.search_ip, held_ip);
                cnt--;
                if (cnt == 0) begin
                    bus.ip_filter_done = 1'b1;
                    bus.found          = in_tbl(held_ip);
                end
            end else if (late_req != late_ack) begin
                late_ack           = late_req;
                bus.ip_filter_done = 1'b1;
                bus.found          = 1'b1;
            end
            if (bus.ip_filter_req) begin
                check("req_pulse", 32'(prev_req), 32'd0);
                check("req_overlap", cnt, 32'd0);
                check("req_expected", 32'(exp_search.size() != 0), 32'd1);
                if (exp_search.size() != 0) check("search_ip", bus.search_ip, exp_search.pop_front());
                n_req++;
                req_cyc = cyc;
                held_ip = bus.search_ip;
                if (!never_done) cnt = (fixed_lat != 0) ? fixed_lat : $urandom_range(34, 2);
            end
            prev_req = bus.ip_filter_req;
        end
    end

    bit e_drop;
    bit prev_rv = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            bus.res_rd = 1'b0;
            prev_rv    = 1'b0;
            exp_drops  = 0;
        end else begin
            if (bus.res_valid && !prev_rv) rise_cyc = cyc;
            prev_rv    = bus.res_valid;
            bus.res_rd = bus.res_valid && !hold_res;
            if (bus.res_rd) begin
                check("res_expected", 32'(exp_drop.size() != 0), 32'd1);
                if (exp_drop.size() != 0) begin
                    e_drop = exp_drop.pop_front();
                    check("res_drop", 32'(bus.res_drop), 32'(e_drop));
                    if (e_drop) exp_drops++;
                end
                n_res++;
            end
        end
    end

    // Call right after a negedge; leaves the bench on a negedge
    task automatic push(input logic [31:0] s, input logic [31:0] d, input int unsigned budget,
                        output bit ok);
        bus.hdr_src_ip = s;
        bus.hdr_dst_ip = d;
        bus.hdr_valid  = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < int'(budget); k++) begin
            if (bus.hdr_ready) begin
                ok      = 1'b1;
                acc_cyc = cyc;
                exp_search.push_back(s);
                if (never_done) begin
                    exp_drop.push_back(1'b1);
                end else begin
                    if (!in_tbl(s)) exp_search.push_back(d);
                    exp_drop.push_back(in_tbl(s) || in_tbl(d));
                end
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.hdr_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int unsigned k = 0;
        while ((exp_drop.size() != 0 || exp_search.size() != 0) && k < 600) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(exp_drop.size() + exp_search.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hdr_ready"}, 32'(bus.hdr_ready), 32'd1);
        check({tag, "_req"}, 32'(bus.ip_filter_req), 32'd0);
        check({tag, "_search_ip"}, bus.search_ip, 32'd0);
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_res_drop"}, 32'(bus.res_drop), 32'd0);
`ifdef IP_FILTER_STATS_EN
        check({tag, "_drop_cnt"}, drop_count, 32'd0);
        check({tag, "_tmo_cnt"}, 32'(timeout_count), 32'd0);
`endif
    endtask

    bit          ok;
    int unsigned base;
    int unsigned accepted;
    int unsigned k;
    initial begin
        bus.hdr_valid  = 1'b0;
        bus.hdr_src_ip = '0;
        bus.hdr_dst_ip = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // Src in table: single lookup, best-case latency
        base = n_req;
        push(32'h0A00_0001, 32'h0A00_0002, 10, ok);
        drain("t1_drain");
        check("t1_nreq", n_req - base, 32'd1);
        check("t1_latency", rise_cyc - acc_cyc, 32'd5);

        // Dst in table: two lookups
        base = n_req;
        push(32'h0101_0101, 32'h0A00_0001, 10, ok);
        drain("t2_drain");
        check("t2_nreq", n_req - base, 32'd2);

        // Neither in table, slow filter
        fixed_lat = 33;
        base = n_req;
        push(32'h0101_0101, 32'h0202_0202, 10, ok);
        drain("t3_drain");
        check("t3_nreq", n_req - base, 32'd2);
        check("t3_done_to_res", rise_cyc - req_cyc, 32'd34);

        // src == dst, not found: both lookups still issued
        fixed_lat = 0;
        base = n_req;
        push(32'h0303_0303, 32'h0303_0303, 10, ok);
        drain("t3b_drain");
        check("t3b_nreq", n_req - base, 32'd2);

        // Backpressure: FSM holds one pair, FIFO holds DEPTH more
        hold_res = 1'b1;
        base     = n_res;
        accepted = 0;
        push(32'h0A00_0001, 32'h0909_0909, 10, ok); accepted += 32'(ok);
        push(32'h0101_0101, 32'h0202_0202, 10, ok); accepted += 32'(ok);
        push(32'h0303_0303, 32'h0A00_0001, 10, ok); accepted += 32'(ok);
        push(32'h0404_0404, 32'h0505_0505, 10, ok); accepted += 32'(ok);
        push(32'h0A00_0001, 32'h0A00_0001, 10, ok); accepted += 32'(ok);
        check("t4_accepted", accepted, 32'd5);
        check("t4_hdr_ready_full", 32'(bus.hdr_ready), 32'd0);
        push(32'h0606_0606, 32'h0707_0707, 3, ok);
        check("t4_refused", 32'(ok), 32'd0);
        hold_res = 1'b0;
        drain("t4_drain");
        check("t4_nres", n_res - base, 32'd5);

        // Filter never answers: fail-closed timeout, then a late done must be ignored
        never_done = 1'b1;
        hold_res   = 1'b1;
        push(32'h0101_0101, 32'h0202_0202, 10, ok);
        exp_timeouts++;
        k = 0;
        while (!bus.res_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t5_res_valid", 32'(bus.res_valid), 32'd1);
        @(negedge clk);
        check("t5_timeout_lat", rise_cyc - req_cyc, 32'd65);
`ifdef IP_FILTER_STATS_EN
        check("t5_tmo_cnt", 32'(timeout_count), exp_timeouts);
`endif
        base = n_req;
        late_req++;
        repeat (4) @(negedge clk);
        check("t5_hold_valid", 32'(bus.res_valid), 32'd1);
        check("t5_hold_drop", 32'(bus.res_drop), 32'd1);
        check("t5_no_req", n_req - base, 32'd0);
        never_done = 1'b0;
        hold_res   = 1'b0;
        drain("t5_drain");
        base = n_req;
        push(32'h0101_0101, 32'h0202_0202, 10, ok);
        drain("t5_next_drain");
        check("t5_next_nreq", n_req - base, 32'd2);
`ifdef IP_FILTER_STATS_EN
        check("t5_drop_cnt", drop_count, exp_drops);
        check("t5_tmo_cnt_end", 32'(timeout_count), exp_timeouts);
`endif

        // Asynchronous reset during the dst lookup
        fixed_lat = 10;
        base = n_req;
        push(32'h0101_0101, 32'h0202_0202, 10, ok);
        k = 0;
        while (n_req < base + 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t6_reach_dst", n_req - base, 32'd2);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        exp_search.delete();
        exp_drop.delete();
        exp_timeouts = 0;
        #1;
        check_reset_outputs("t6_async");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        base = n_req;
        push(32'h0A00_0001, 32'h0505_0505, 10, ok);
        drain("t6_drain");
        check("t6_nreq", n_req - base, 32'd1);
`ifdef IP_FILTER_STATS_EN
        check("t6_drop_cnt", drop_count, exp_drops);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
